// File: rtl/lsu.sv
// Load/store unit: one outstanding RV32I load or store against a combinational-read data RAM.
// Request is checked for width, alignment and range on acceptance; faults skip the RAM entirely.
package lsu_pkg;
  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_e;

  typedef enum logic [1:0] {
    RAM_MASK_W = 2'b00,
    RAM_MASK_B = 2'b01,
    RAM_MASK_H = 2'b10
  } ram_mask_e;
endpackage

module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_BITS = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_fault,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output mem_op_e     ram_mem_op,
  output ram_mask_e   ram_mask,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_e;

  state_e      r_state;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_ram_addr;
  logic [31:0] r_ram_wdata;
  ram_mask_e   r_ram_mask;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic [4:0]  r_resp_rd;
  logic        r_resp_fault;

  logic        w_illegal;
  logic        w_misalign;
  logic        w_out_of_range;
  logic        w_fault;
  ram_mask_e   w_mask;
  logic [31:0] w_wdata_aligned;
  logic [31:0] w_load_data;

  always_comb begin
    w_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                (req_funct3 == 3'b111) || (req_store && req_funct3[2]);
    w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_out_of_range = (req_addr >> ADDR_BITS) != 32'd0;
    w_fault = w_illegal || w_misalign || w_out_of_range;
  end

  always_comb begin
    w_mask          = RAM_MASK_W;
    w_wdata_aligned = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_mask          = RAM_MASK_B;
        w_wdata_aligned = {24'd0, req_wdata[7:0]};
      end
      2'b01: begin
        w_mask          = RAM_MASK_H;
        w_wdata_aligned = {16'd0, req_wdata[15:0]};
      end
      default: begin
        w_mask          = RAM_MASK_W;
        w_wdata_aligned = req_wdata;
      end
    endcase
  end

  // funct3[2] selects zero- versus sign-extension of the RAM's right-aligned data
  always_comb begin
    w_load_data = ram_rdata;
    case (r_funct3)
      3'b000:  w_load_data = {{24{ram_rdata[7]}}, ram_rdata[7:0]};
      3'b100:  w_load_data = {24'd0, ram_rdata[7:0]};
      3'b001:  w_load_data = {{16{ram_rdata[15]}}, ram_rdata[15:0]};
      3'b101:  w_load_data = {16'd0, ram_rdata[15:0]};
      default: w_load_data = ram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_store      <= 1'b0;
      r_funct3     <= 3'd0;
      r_ram_addr   <= 32'd0;
      r_ram_wdata  <= 32'd0;
      r_ram_mask   <= RAM_MASK_W;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_rd    <= 5'd0;
      r_resp_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_store      <= req_store;
            r_funct3     <= req_funct3;
            r_resp_rd    <= req_rd;
            r_resp_rdata <= 32'd0;
            r_resp_fault <= w_fault;
            if (w_fault) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
            end else begin
              r_state     <= S_ACCESS;
              r_ram_addr  <= req_addr;
              r_ram_mask  <= w_mask;
              r_ram_wdata <= req_store ? w_wdata_aligned : 32'd0;
            end
          end
        end
        S_ACCESS: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= r_store ? 32'd0 : w_load_data;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gated by rst combinationally so a reset landing in the store cycle blocks the write
  assign ram_mem_op = (r_state == S_ACCESS && r_store && !rst) ? MEM_STORE : MEM_LOAD;
  assign req_ready  = (r_state == S_IDLE);
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign ram_mask   = r_ram_mask;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_rd    = r_resp_rd;
  assign resp_fault = r_resp_fault;

endmodule
